// File: rtl/sub_sched_pkg.sv
// Shared constants, FSM state type and nibble-step helper for the nibble-serial subtractor scheduler.
package sub_sched_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nstep(input int width);
        return width / NIBBLE;
    endfunction

endpackage

// File: rtl/sub4_bin.sv
// Combinational 4-bit ripple-borrow subtractor, one xor/not/and/or cell per bit so the
// netlist matches the gate-level subtractor used for fault enumeration.
module sub4_bin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [4:0] brw;

    assign brw[0] = bin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic axb;
        assign axb        = a[i] ^ b[i];
        assign d[i]       = axb ^ brw[i];
        assign brw[i + 1] = (~a[i] & b[i]) | (~axb & brw[i]);
    end

    assign bout = brw[4];

endmodule

// File: rtl/sub_nibble_sched.sv
// Two-requester round-robin front end that runs WIDTH-bit subtractions through one
// shared 4-bit subtractor, one nibble per cycle, LSB first.
//
// state | meaning
// IDLE  | waiting for a request; arbiter drives reqX_ready
// RUN   | one nibble per cycle through sub4_bin, borrow carried in a register
// DONE  | result presented on res_*, waiting for res_ready
module sub_nibble_sched
    import sub_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_diff,
    output logic             res_borrow,
    output logic             res_id,
    output logic             busy
);

    localparam int NSTEP = nstep(WIDTH);
    localparam int IW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSTEP - 1);

    state_t           state;
    logic             ptr;
    logic [IW-1:0]    idx;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             id_q;
    logic             valid_q;
    logic             busy_q;

    logic             grant;
    logic             acc0;
    logic             acc1;
    logic [IW+1:0]    base;
    logic [3:0]       nib_d;
    logic             nib_bout;

    // On a tie the pointer decides; a lone requester always wins.
    assign grant      = (req0_valid && req1_valid) ? ptr : req1_valid;
    assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state == IDLE) && req1_valid && grant;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    assign base = {idx, 2'b00};

    sub4_bin u_sub4 (
        .a    (a_q[base +: NIBBLE]),
        .b    (b_q[base +: NIBBLE]),
        .bin  (borrow),
        .d    (nib_d),
        .bout (nib_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            idx     <= '0;
            borrow  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        a_q    <= acc1 ? req1_a : req0_a;
                        b_q    <= acc1 ? req1_b : req0_b;
                        id_q   <= acc1;
                        borrow <= 1'b0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff_q[base +: NIBBLE] <= nib_d;
                    borrow <= nib_bout;
                    idx    <= idx + IW'(1);
                    if (idx == LAST) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        ptr     <= ~id_q;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid  = valid_q;
    assign busy       = busy_q;
    assign res_diff   = diff_q;
    assign res_borrow = borrow;
    assign res_id     = id_q;

endmodule

// File: tb/tb_sub_nibble_sched.sv
// Directed bench for sub_nibble_sched at WIDTH=16 and WIDTH=8.
module tb_sub_nibble_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b, res_diff;
    logic        res_valid, res_ready, res_borrow, res_id, busy;

    logic        e_req0_valid, e_req0_ready, e_req1_valid, e_req1_ready;
    logic [7:0]  e_req0_a, e_req0_b, e_req1_a, e_req1_b, e_res_diff;
    logic        e_res_valid, e_res_ready, e_res_borrow, e_res_id, e_busy;

    int n_cmp = 0;
    int n_bad = 0;

    sub_nibble_sched #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_diff(res_diff),
        .res_borrow(res_borrow), .res_id(res_id), .busy(busy)
    );

    sub_nibble_sched #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(e_req0_valid), .req0_ready(e_req0_ready), .req0_a(e_req0_a), .req0_b(e_req0_b),
        .req1_valid(e_req1_valid), .req1_ready(e_req1_ready), .req1_a(e_req1_a), .req1_b(e_req1_b),
        .res_valid(e_res_valid), .res_ready(e_res_ready), .res_diff(e_res_diff),
        .res_borrow(e_res_borrow), .res_id(e_res_id), .busy(e_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One job on the 16-bit instance with res_ready high; returns to IDLE at the end.
    task automatic run_job(input logic id, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] ed, input logic eb);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        chk("job_ready", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'hFFFF; req1_a = 16'hFFFF; req0_b = 16'h0000; req1_b = 16'h0000;
        chk("job_busy", busy, 1'b1);
        repeat (3) step();
        chk("job_early_valid", res_valid, 1'b0);
        step();
        chk("job_valid", res_valid, 1'b1);
        chk("job_diff", res_diff, ed);
        chk("job_borrow", res_borrow, eb);
        chk("job_id", res_id, id);
        step();
        chk("job_idle_valid", res_valid, 1'b0);
        chk("job_idle_busy", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0; res_ready = 1'b1;
        req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;
        e_req0_valid = 1'b0; e_req1_valid = 1'b0; e_res_ready = 1'b1;
        e_req0_a = 8'h0; e_req0_b = 8'h0; e_req1_a = 8'h0; e_req1_b = 8'h0;
        step();
        step();
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_diff", res_diff, 16'h0);
        chk("rst_id", res_id, 1'b0);
        req0_valid = 1'b0;
        rst = 1'b0;
        step();

        run_job(1'b0, 16'h1234, 16'h0001, 16'h1233, 1'b0);
        run_job(1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0);
        run_job(1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1);

        // Tie from reset: alternation 0,1,0,1 at six cycles per job.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_a = 16'h0010; req0_b = 16'h0001; req1_a = 16'h0005; req1_b = 16'h0007;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("tie_ready", {req1_ready, req0_ready}, (j % 2 == 1) ? 2'b10 : 2'b01);
            step();
            chk("tie_run_ready", {req1_ready, req0_ready}, 2'b00);
            repeat (3) step();
            chk("tie_early_valid", res_valid, 1'b0);
            step();
            chk("tie_id", res_id, 32'(j % 2));
            chk("tie_diff", res_diff, (j % 2 == 1) ? 16'hFFFE : 16'h000F);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Consumer stall in DONE.
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h00F0; req1_b = 16'h000F;
        step();
        req1_valid = 1'b0;
        repeat (4) step();
        chk("hold_enter", res_valid, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_diff", res_diff, 16'h00E1);
            chk("hold_id", res_id, 1'b1);
            chk("hold_ready", {req1_ready, req0_ready}, 2'b00);
        end
        res_ready = 1'b1;
        step();
        chk("hold_release", res_valid, 1'b0);
        chk("hold_keep_diff", res_diff, 16'h00E1);
        chk("hold_keep_id", res_id, 1'b1);
        chk("hold_ptr_ready", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Reset during the second RUN cycle.
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001;
        step();
        req0_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_diff", res_diff, 16'h0);
        chk("mid_rst_borrow", res_borrow, 1'b0);
        chk("mid_rst_id", res_id, 1'b0);
        req0_valid = 1'b1;
        #1;
        chk("mid_rst_ready", req0_ready, 1'b0);
        req0_valid = 1'b0;
        rst = 1'b0;
        step();
        run_job(1'b1, 16'h00FF, 16'h0F0F, 16'hF1F0, 1'b1);

        // WIDTH=8 instance.
        e_req0_valid = 1'b1; e_req0_a = 8'h05; e_req0_b = 8'h07;
        #1;
        chk("w8_ready", e_req0_ready, 1'b1);
        step();
        e_req0_valid = 1'b0;
        step();
        chk("w8_early_valid", e_res_valid, 1'b0);
        step();
        chk("w8_valid", e_res_valid, 1'b1);
        chk("w8_diff", e_res_diff, 8'hFE);
        chk("w8_borrow", e_res_borrow, 1'b1);
        chk("w8_id", e_res_id, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sub_nibble_sched.md
# sub_nibble_sched

Sequencing and arbitration controller for a shared 4-bit ripple-borrow subtractor. Two requesters submit WIDTH-bit subtraction jobs. The block grants one job at a time round-robin and feeds the 4-bit subtractor one nibble per cycle, LSB first, carrying the borrow between nibbles in a register. It returns the full difference, the final borrow and the winning requester id. It sits between the fault-simulation pattern sources and the single gate-level subtractor instance, so one subtractor netlist serves wider operands and multiple clients.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a job
- req0_ready  output  1  requester 0 job accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 minuend, subtrahend
- req1_valid / req1_ready / req1_a / req1_b  same as requester 0, for requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_diff  output  WIDTH  a − b modulo 2^WIDTH
- res_borrow  output  1  final borrow-out, 1 iff a < b (unsigned)
- res_id  output  1  requester that issued the job
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. NSTEP = WIDTH/4.
- IDLE:
  - Grant when any req valid. If one valid, grant it. If both valid, grant the one selected by priority pointer `ptr` (reset 0).
  - `reqX_ready` = (state==IDLE) && grant==X, combinational.
  - Handshake (valid && ready): latch a, b, id; clear borrow and nibble index; go RUN.
- RUN: each cycle, nibble k = index:
  - Sub-module computes d = a[k] − b[k] − borrow.
  - Per-bit borrow: bout = (~a & b) | (~(a ^ b) & bin).
  - Write d into result nibble k; borrow ← nibble bout; index++.
  - After nibble NSTEP−1, go DONE.
- DONE:
  - res_valid = 1, holding res_diff, res_borrow and res_id stable.
  - On res_valid && res_ready: go IDLE and set ptr ← ~res_id, so the other requester wins the next tie.
- No job accepted outside IDLE. Both reqX_ready are 0 in RUN and DONE.
- Request operands are sampled only at the handshake edge; later changes have no effect.
- res_diff, res_borrow and res_id keep their last values until the next handshake. They are not cleared on leaving DONE.
- rst (any state, including mid-RUN and DONE):
  - state IDLE, ptr 0, index 0, borrow 0
  - res_diff 0, res_borrow 0, res_id 0, res_valid 0, busy 0
  - in-flight job discarded, no result produced

## Timing
- Accept edge E: RUN occupies cycles E+1 … E+NSTEP. res_valid is high from cycle E+NSTEP+1.
- For WIDTH=16, res_valid rises 5 cycles after accept.
- Result handshake edge R returns to IDLE. The earliest next accept is edge R+1, so back-to-back throughput is NSTEP+2 cycles per job.
- Reset values of all outputs: 0. reqX_ready also evaluates to 0 during rst.
- Simultaneous valid on both requesters: exactly one ready is asserted. Never both.
- Borrow out of nibble k is used by nibble k+1 in the next cycle only. No combinational path spans nibbles.

## Structure
- Package `sub_sched_pkg`: NIBBLE=4 constant, state enum {IDLE, RUN, DONE}, and an nstep(WIDTH) function.
- Sub-module `sub4_bin`: purely combinational 4-bit subtractor with borrow-in and borrow-out, built from the same per-bit xor/not/and/or structure as the existing subtractor netlist, so fault enumeration covers it.
- The top level holds the FSM, arbiter pointer, operand/result registers, and the nibble mux/demux.

## Test plan
- req0 a=0x1234, b=0x0001 → 5 cycles after accept: res_valid, diff 0x1233, borrow 0, id 0.
- Borrow chain: a=0x1000, b=0x0001 → 0x0FFF, borrow 0. Then a=0x0000, b=0x0001 → 0xFFFF, borrow 1.
- Both requesters valid continuously from reset, res_ready tied 1 → ids 0,1,0,1 over 4 jobs; each job takes 6 cycles from accept to accept.
- res_ready held low 3 cycles in DONE → res_valid, diff and id stable; req0_ready and req1_ready stay 0; completes on the 4th cycle.
- rst asserted during the 2nd RUN cycle → next cycle: all outputs 0, busy 0. A following req1 job a=0x00FF, b=0x0F0F → 0xF1F0, borrow 1, id 1.
- WIDTH=8, a=0x05, b=0x07 → res_valid 3 cycles after accept, diff 0xFE, borrow 1.
